// File: rtl/change_pkg.sv
// Shared definitions for the change dispenser slice.
//   state_t      : dispenser FSM states
//   coin_t       : which coin (if any) to eject
//   COIN_*       : coin values in cents
//   pick_coin()  : largest legal coin not exceeding a remaining amount
//   coin_value() : cents value of a coin_t
package change_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DISPENSE,
    S_GAP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    C_NONE,
    C_NICKLE,
    C_DIME,
    C_QUARTER
  } coin_t;

  localparam int unsigned COIN_QUARTER = 25;
  localparam int unsigned COIN_DIME    = 10;
  localparam int unsigned COIN_NICKLE  = 5;

  // Largest-coin-first selection. Quarters only take part when the
  // quarter return feature is built in.
  function automatic coin_t pick_coin(input int unsigned rem, input logic quarter_en);
    if (quarter_en && rem >= COIN_QUARTER) return C_QUARTER;
    if (rem >= COIN_DIME)                  return C_DIME;
    if (rem >= COIN_NICKLE)                return C_NICKLE;
    return C_NONE;
  endfunction

  function automatic int unsigned coin_value(input coin_t c);
    case (c)
      C_QUARTER: return COIN_QUARTER;
      C_DIME:    return COIN_DIME;
      C_NICKLE:  return COIN_NICKLE;
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/change_gap_timer.sv
// Inter-coin gap timer: a down-counter that is loaded with GAP_CYCLES when a
// coin is ejected and counts while the dispenser sits in its gap state.
// Ports:
//   clk, reset : clock, async active-high reset
//   load       : reload the counter with GAP_CYCLES
//   en         : count down this cycle (dispenser is in the gap state)
//   clr        : abandon the current gap (sale reset)
//   expired    : last gap cycle; the dispenser may leave the gap state
module change_gap_timer #(
  parameter int GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Expiry is flagged while the count still reads 1, so the gap state lasts
  // exactly GAP_CYCLES cycles.
  assign expired = en && (cnt == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(GAP_CYCLES);
    end else if (en && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: downstream stage of the vending machine.
// On the rising edge of candy it latches change = num - PRICE (floored at 0)
// and pays it out, largest coin first, as one-cycle eject pulses paced by
// mech_ready and a fixed inter-coin gap. done is held until candy falls.
// Build option: define QUARTER_RETURN_EN to make the quarter a legal coin
// (tried before the dime); otherwise eject_quarter is tied 0.
// Ports:
//   clk, reset     : clock, async active-high reset
//   candy          : purchase flag from the vending machine
//   num            : vending machine running total, cents
//   mech_ready     : coin mechanism can take a pulse this cycle
//   eject_quarter/eject_dime/eject_nickle : one-cycle eject pulses
//   change_left    : cents still owed
//   busy           : LOAD/DISPENSE/GAP in progress
//   done           : change fully paid, held until candy falls
//   fault          : sticky, sub-nickel residue could not be paid
module change_dispenser
  import change_pkg::*;
#(
  parameter int PRICE      = 25,
  parameter int WIDTH      = 6,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             candy,
  input  logic [WIDTH-1:0] num,
  input  logic             mech_ready,
  output logic             eject_dime,
  output logic             eject_nickle,
  output logic             eject_quarter,
  output logic [WIDTH-1:0] change_left,
  output logic             busy,
  output logic             done,
  output logic             fault
);

`ifdef QUARTER_RETURN_EN
  localparam logic QUARTER_EN = 1'b1;
`else
  localparam logic QUARTER_EN = 1'b0;
`endif

  localparam logic [WIDTH-1:0] PRICE_W  = WIDTH'(PRICE);
  localparam logic [WIDTH-1:0] NICKLE_W = WIDTH'(COIN_NICKLE);

  state_t           state;
  logic [WIDTH-1:0] remaining;
  logic             candy_q;
  logic             start;
  logic             fall;
  coin_t            coin;
  logic [WIDTH-1:0] coin_w;
  logic             fire;
  logic             gap_expired;

  assign start = candy & ~candy_q;
  assign fall  = ~candy & candy_q;

  assign coin   = pick_coin(int'(remaining), QUARTER_EN);
  assign coin_w = WIDTH'(coin_value(coin));

  // A coin goes out this cycle; also the gap timer's reload strobe.
  assign fire = (state == S_DISPENSE) && !fall && (remaining >= NICKLE_W) && mech_ready;

  assign change_left = remaining;

  change_gap_timer #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_gap (
    .clk     (clk),
    .reset   (reset),
    .load    (fire),
    .en      (state == S_GAP),
    .clr     (fall),
    .expired (gap_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      remaining    <= '0;
      candy_q      <= 1'b0;
      eject_dime   <= 1'b0;
      eject_nickle <= 1'b0;
`ifdef QUARTER_RETURN_EN
      eject_quarter <= 1'b0;
`endif
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
    end else begin
      candy_q      <= candy;
      // Eject strobes default low so each is a single-cycle pulse.
      eject_dime   <= 1'b0;
      eject_nickle <= 1'b0;
`ifdef QUARTER_RETURN_EN
      eject_quarter <= 1'b0;
`endif
      if (fall && state != S_IDLE) begin
        // Sale reset: abandon whatever is in flight, owe nothing further.
        state     <= S_IDLE;
        remaining <= '0;
        busy      <= 1'b0;
        done      <= 1'b0;
        fault     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state <= S_LOAD;
              busy  <= 1'b1;
            end
          end
          S_LOAD: begin
            // Underpayment floors to zero rather than wrapping.
            remaining <= (num >= PRICE_W) ? num - PRICE_W : '0;
            state     <= S_DISPENSE;
          end
          S_DISPENSE: begin
            if (remaining == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (remaining < NICKLE_W) begin
              // No coin small enough: write the residue off and flag it.
              fault     <= 1'b1;
              remaining <= '0;
              state     <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else if (fire) begin
              remaining <= remaining - coin_w;
              state     <= S_GAP;
              case (coin)
`ifdef QUARTER_RETURN_EN
                C_QUARTER: eject_quarter <= 1'b1;
`endif
                C_DIME:    eject_dime    <= 1'b1;
                C_NICKLE:  eject_nickle  <= 1'b1;
                default:   ;
              endcase
            end
          end
          S_GAP: begin
            if (gap_expired) state <= S_DISPENSE;
          end
          S_DONE: ;  // held until candy falls
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifndef QUARTER_RETURN_EN
  assign eject_quarter = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
  localparam int PRICE = 25;
  localparam int WIDTH = 6;
  localparam int GAP   = 2;
`ifdef QUARTER_RETURN_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             candy;
  logic [WIDTH-1:0] num;
  logic             mech_ready;
  logic             eject_dime, eject_nickle, eject_quarter;
  logic [WIDTH-1:0] change_left;
  logic             busy, done, fault;

  change_dispenser #(.PRICE(PRICE), .WIDTH(WIDTH), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .reset        (reset),
    .candy        (candy),
    .num          (num),
    .mech_ready   (mech_ready),
    .eject_dime   (eject_dime),
    .eject_nickle (eject_nickle),
    .eject_quarter(eject_quarter),
    .change_left  (change_left),
    .busy         (busy),
    .done         (done),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_pulse = -1;
  int sb[$];
  int residue;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample #1 later, and score any eject pulse.
  task automatic tick();
    int obs;
    @(posedge clk);
    #1;
    cyc++;
    if (eject_dime || eject_nickle || eject_quarter) begin
      obs = eject_quarter ? 25 : (eject_dime ? 10 : 5);
      chk("onehot", int'(eject_dime) + int'(eject_nickle) + int'(eject_quarter), 1);
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_pulse: got coin %0d expected none", obs);
      end
      if (sb.size() > 0) chk("coin", obs, sb.pop_front());
      if (last_pulse >= 0) chk("pulse_spacing", cyc - last_pulse, GAP + 1);
      last_pulse = cyc;
    end
  endtask

  // Reference model: greedy coin list for a sale, returns the unpayable residue.
  task automatic expect_sale(input int n, output int res);
    int ch;
    int c;
    ch = (n >= PRICE) ? n - PRICE : 0;
    while (ch >= 5) begin
      c = (QEN && ch >= 25) ? 25 : (ch >= 10 ? 10 : 5);
      sb.push_back(c);
      ch -= c;
    end
    res = ch;
    last_pulse = -1;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 80 && done !== 1'b1; i++) tick();
    chk(tag, int'(done), 1);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_left"}, int'(change_left), 0);
  endtask

  task automatic end_sale(input string tag);
    candy = 1'b0;
    tick();
    chk({tag, "_done_clr"}, int'(done), 0);
    chk({tag, "_fault_clr"}, int'(fault), 0);
    chk({tag, "_busy_clr"}, int'(busy), 0);
  endtask

  task automatic run_sale(input int n, input string tag);
    expect_sale(n, residue);
    num = WIDTH'(n);
    candy = 1'b1;
    wait_done(tag);
    chk({tag, "_fault"}, int'(fault), int'(residue != 0));
    end_sale(tag);
  endtask

  initial begin
    reset = 1'b1; candy = 1'b0; num = '0; mech_ready = 1'b1;
    #12;
    chk("rst_outputs", {eject_dime, eject_nickle, eject_quarter, busy, done, fault}, 0);
    chk("rst_left", int'(change_left), 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Exact payment: no coins, done on the third edge.
    expect_sale(25, residue);
    num = 6'd25; candy = 1'b1;
    tick(); tick();
    chk("t1_done_early", int'(done), 0);
    chk("t1_busy", int'(busy), 1);
    tick();
    chk("t1_done", int'(done), 1);
    chk("t1_fault", int'(fault), 0);
    chk("t1_sb", sb.size(), 0);
    end_sale("t1");

    // One nickel, first pulse three edges after the rise.
    expect_sale(30, residue);
    num = 6'd30; candy = 1'b1;
    tick(); tick();
    chk("t2_left_loaded", int'(change_left), 5);
    tick();
    chk("t2_first_pulse", int'(eject_nickle), 1);
    chk("t2_left_after", int'(change_left), 0);
    wait_done("t2");
    chk("t2_fault", int'(fault), 0);
    end_sale("t2");

    // Two dimes with gap spacing; 50 exercises quarter (or dime/dime/nickel).
    run_sale(45, "t3a");
    run_sale(50, "t3b");

    // Mechanism stalled: nothing issues until mech_ready returns.
    mech_ready = 1'b0; num = 6'd40; candy = 1'b1;
    repeat (8) tick();
    chk("t4_busy_stalled", int'(busy), 1);
    chk("t4_left_stalled", int'(change_left), 15);
    expect_sale(40, residue);
    mech_ready = 1'b1;
    wait_done("t4");
    end_sale("t4");

    // Candy drops after the first dime: abandon, no second pulse.
    sb.push_back(10); last_pulse = -1;
    num = 6'd45; candy = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("t5_first_dime", sb.size(), 0);
    candy = 1'b0;
    repeat (10) tick();
    chk("t5_done", int'(done), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_left", int'(change_left), 0);

    // Async reset while a pulse is high: everything drops at once.
    sb.push_back(10); last_pulse = -1;
    candy = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("t5r_pulse_seen", int'(eject_dime), 1);
    reset = 1'b1;
    #1;
    chk("t5r_eject", {eject_dime, eject_nickle, eject_quarter}, 0);
    chk("t5r_busy", int'(busy), 0);
    chk("t5r_left", int'(change_left), 0);
    candy = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Residue below a nickel: fault with done, cleared by candy fall.
    run_sale(27, "t6a");
    run_sale(52, "t6b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
